// File: rtl/ram_if_pkg.sv
// Shared types and constants for the change-detect RAM initiator (ram_master).
package ram_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2
    } ram_state_e;

    localparam int RAM_DATA_W_DEF  = 32;
    localparam int RAM_ADDR_W_DEF  = 32;
    localparam int RAM_SETTLE_DEF  = 2;
    localparam int RAM_SETTLE_MIN  = 2;
    localparam int RAM_TIMEOUT_DEF = 16;

    // The RAM needs one edge to drop response and one to raise it again.
    function automatic int settle_clamp(input int settle);
        if (settle < RAM_SETTLE_MIN) begin
            return RAM_SETTLE_MIN;
        end else begin
            return settle;
        end
    endfunction

endpackage

// File: rtl/ram_master.sv
// Initiator for the change-detect RAM: one request in flight, response sampled after a settle window.
// Optional WAIT-state timeout is enabled by defining RAM_MASTER_TIMEOUT_EN.
module ram_master
    import ram_if_pkg::*;
#(
    parameter int DATA_W         = RAM_DATA_W_DEF,
    parameter int ADDR_W         = RAM_ADDR_W_DEF,
    parameter int SETTLE         = RAM_SETTLE_DEF,
    parameter int TIMEOUT_CYCLES = RAM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    input  logic              ram_response,
    input  logic [DATA_W-1:0] ram_out,
    output logic              err
);

    localparam int SETTLE_EFF = settle_clamp(SETTLE);
    localparam int SET_W      = $clog2(SETTLE_EFF);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_EFF - 1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

`ifdef RAM_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0]   wait_cnt_q;
`endif

    ram_state_e        state_q;
    logic [SET_W-1:0]  settle_cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] ram_data_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_wr_q;
    logic              err_q;

    // Request FSM; ram_* only change on an accepted request so the RAM is never retriggered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            ram_data_q   <= '0;
            ram_addr_q   <= '0;
            ram_wr_q     <= 1'b0;
            err_q        <= 1'b0;
`ifdef RAM_MASTER_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        ram_wr_q     <= req_wr;
                        ram_addr_q   <= req_addr;
                        ram_data_q   <= req_data;
                        settle_cnt_q <= SET_LOAD;
                        req_ready_q  <= 1'b0;
                        state_q      <= ST_SETTLE;
                    end else begin
                        req_ready_q  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // A stale high response from the previous op is not trusted here.
                    if (settle_cnt_q == '0) begin
                        state_q    <= ST_WAIT;
`ifdef RAM_MASTER_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SET_ONE;
                    end
                end
                ST_WAIT: begin
                    if (ram_response) begin
                        rsp_data_q  <= ram_out;
                        rsp_valid_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
`ifdef RAM_MASTER_TIMEOUT_EN
                    else if (wait_cnt_q == TO_LAST) begin
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + TO_ONE;
                    end
`else
                    else begin
                        state_q     <= ST_WAIT;
                    end
`endif
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ram_data  = ram_data_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ram_master.sv
// Directed self-checking bench for ram_master with a behavioural change-detect RAM model.
module tb_ram_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] ram_data;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        ram_response;
    logic [31:0] ram_out;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_master #(
        .DATA_W(32), .ADDR_W(32), .SETTLE(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_wr(ram_wr),
        .ram_response(ram_response), .ram_out(ram_out), .err(err)
    );

    // RAM model: restart on any input change, drop response one edge, then execute.
    logic [31:0] mem [0:15] = '{default: 32'h0};
    logic [64:0] last_q = 65'd0;
    logic        resp_q = 1'b1;
    logic        pend_q = 1'b0;
    logic [31:0] out_q  = 32'd0;
    logic        force_zero = 1'b0;

    assign ram_response = resp_q & ~force_zero;
    assign ram_out      = out_q;

    always @(posedge clk) begin
        if ({ram_wr, ram_addr, ram_data} !== last_q) begin
            last_q <= {ram_wr, ram_addr, ram_data};
            resp_q <= 1'b0;
            pend_q <= 1'b1;
        end else if (pend_q) begin
            pend_q <= 1'b0;
            resp_q <= 1'b1;
            if (last_q[64]) begin
                mem[last_q[35:32]] <= last_q[31:0];
                out_q <= last_q[31:0];
            end else begin
                out_q <= mem[last_q[35:32]];
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input bit now, output bit ok);
        if (!now) @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound, output int lat, output logic [31:0] d);
        lat = -1;
        d   = 32'd0;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = i;
                d   = rsp_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, err, ram_wr} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/rsp_valid/err/wr=%b required 1000",
                     {req_ready, rsp_valid, err, ram_wr});
        end
        n_tests++;
        if ({rsp_data, ram_data, ram_addr} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_buses: got rsp_data=%h ram_data=%h ram_addr=%h required 0",
                     rsp_data, ram_data, ram_addr);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write_read();
        bit ok; int lat; logic [31:0] d;
        issue(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, ok);
        n_tests++;
        if (!ok || ram_wr !== 1'b1 || ram_addr !== 32'd5 || ram_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_drive: got ok=%0d wr=%b addr=%h data=%h required 1 1 5 deadbeef",
                     ok, ram_wr, ram_addr, ram_data);
        end
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== 3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_latency: got lat=%0d err=%b required 3 0", lat, err);
        end
        issue(1'b0, 32'd5, 32'd0, 1'b0, ok);
        wait_rsp(40, lat, d);
        n_tests++;
        if (!ok || lat !== 3 || d !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_after_wr: got ok=%0d lat=%0d data=%h required 1 3 deadbeef", ok, lat, d);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, 32'd5, 32'd0, 1'b0, ok);
            wait_rsp(40, lat, d);
            n_tests++;
            if (!ok || lat !== 3 || d !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL b2b_identical_%0d: got ok=%0d lat=%0d data=%h required 1 3 deadbeef",
                         k, ok, lat, d);
            end
        end
    endtask

    task automatic test_busy_hold();
        bit ok; int lat; int busy; logic [31:0] d;
        issue(1'b0, 32'd5, 32'd0, 1'b0, ok);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'd7;
        req_data  = 32'd0;
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) break;
            busy++;
            n_tests++;
            if (ram_addr !== 32'd5 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_hold_%0d: got ram_addr=%h ready=%b required 5 0", i, ram_addr, req_ready);
            end
        end
        n_tests++;
        if (busy !== 2 || rsp_data !== 32'hDEADBEEF || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_first_rsp: got busy=%0d data=%h ready=%b required 2 deadbeef 1",
                     busy, rsp_data, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_tests++;
        if (ram_addr !== 32'd7 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_accept7: got ram_addr=%h ready=%b required 7 0", ram_addr, req_ready);
        end
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== 3 || d !== 32'd0) begin
            n_fail++;
            $display("FAIL busy_rsp7: got lat=%0d data=%h required 3 0", lat, d);
        end
    endtask

    task automatic test_same_cycle_accept();
        bit ok; int lat; logic [31:0] d;
        issue(1'b0, 32'd5, 32'd0, 1'b0, ok);
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== 3 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sc_ready_with_rsp: got lat=%0d ready=%b required 3 1", lat, req_ready);
        end
        issue(1'b1, 32'd1, 32'd1, 1'b1, ok);
        n_tests++;
        if (!ok || ram_addr !== 32'd1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sc_accept: got ok=%0d addr=%h rsp_valid=%b ready=%b required 1 1 0 0",
                     ok, ram_addr, rsp_valid, req_ready);
        end
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL sc_latency: got lat=%0d required 3", lat);
        end
        issue(1'b0, 32'd1, 32'd0, 1'b0, ok);
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== 3 || d !== 32'd1) begin
            n_fail++;
            $display("FAIL sc_readback: got lat=%0d data=%h required 3 1", lat, d);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; bit seen; int lat; logic [31:0] d;
        issue(1'b1, 32'd3, 32'h33, 1'b0, ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if ({req_ready, rsp_valid, err, ram_wr} !== 4'b1000 ||
            {rsp_data, ram_data, ram_addr} !== 96'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got ready/rsp/err/wr=%b rsp_data=%h ram_data=%h ram_addr=%h required 1000 0 0 0",
                     {req_ready, rsp_valid, err, ram_wr}, rsp_data, ram_data, ram_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_rsp: got rsp_valid seen=%b required 0", seen);
        end
        issue(1'b0, 32'd0, 32'd0, 1'b0, ok);
        wait_rsp(40, lat, d);
        n_tests++;
        if (!ok || lat !== 3 || d !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_recover: got ok=%0d lat=%0d data=%h required 1 3 0", ok, lat, d);
        end
    endtask

`ifdef RAM_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int lat; logic [31:0] d;
        force_zero = 1'b1;
        issue(1'b0, 32'd5, 32'd0, 1'b0, ok);
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== 18 || err !== 1'b1 || d !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got lat=%0d err=%b data=%h required 18 1 0", lat, err, d);
        end
        @(posedge clk);
        #1;
        force_zero = 1'b0;
        n_tests++;
        if (err !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_one_cycle: got err=%b rsp_valid=%b ready=%b required 0 0 1",
                     err, rsp_valid, req_ready);
        end
    endtask
`else
    task automatic test_no_timeout();
        bit ok; int lat; logic [31:0] d;
        force_zero = 1'b1;
        issue(1'b0, 32'd5, 32'd0, 1'b0, ok);
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== -1 || err !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_forever: got lat=%0d err=%b ready=%b required -1 0 0", lat, err, req_ready);
        end
        force_zero = 1'b0;
        wait_rsp(40, lat, d);
        n_tests++;
        if (lat !== 1 || d !== 32'hDEADBEEF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_release: got lat=%0d data=%h err=%b required 1 deadbeef 0", lat, d, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_busy_hold();
        test_same_cycle_accept();
        test_reset_mid();
`ifdef RAM_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
